// File: rtl/ldst_unit.sv
// ldst_unit: MEM-stage load/store unit.
// Accepts a LD/ST from EX, runs one req/ack transaction on the data-memory bus,
// and stalls the upstream pipeline while the transaction is outstanding.
//
// Parameters:
//   WAIT_MAX  cycles in REQ without mem_ack before the transaction is abandoned (2..255)
//   CNT_W     wait counter width, must hold WAIT_MAX
//
// Ports:
//   clk, rst_n              clock (rising edge), asynchronous active-low reset
//   ex_valid, opcode        EX stage instruction valid / opcode
//   addr, st_data           effective address and store operand from EX
//   stall                   hold upstream pipeline (combinational)
//   done, bus_err           one-cycle completion pulse / timeout flag with done
//   mem_out                 load result to the writeback data selector
//   mem_req, mem_we         bus request / write enable
//   mem_addr, mem_wdata     bus address / write data, held stable during REQ
//   mem_rdata, mem_ack      bus read data / one-cycle completion
//   misalign                only with LDST_ALIGN_CHK_EN: misaligned op flag with done
//
// Build option: define LDST_ALIGN_CHK_EN to reject misaligned accesses instead of
// forcing mem_addr[1:0] to zero.
module ldst_unit #(
    parameter int unsigned WAIT_MAX = 16,
    parameter int unsigned CNT_W    = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    input  logic [5:0]  opcode,
    input  logic [31:0] addr,
    input  logic [31:0] st_data,
    output logic        stall,
    output logic        done,
    output logic [31:0] mem_out,
    output logic        bus_err,
`ifdef LDST_ALIGN_CHK_EN
    output logic        misalign,
`endif
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    localparam logic [5:0] OPCODE_LD = 6'h23;
    localparam logic [5:0] OPCODE_ST = 6'h2b;
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(WAIT_MAX - 1);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;
    logic             is_mem;

    assign is_mem = ex_valid && (opcode == OPCODE_LD || opcode == OPCODE_ST);
    assign stall  = (state == IDLE && is_mem) || (state == REQ);

    // mem_we doubles as the load/store flag of the op in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_out   <= '0;
            done      <= 1'b0;
            bus_err   <= 1'b0;
`ifdef LDST_ALIGN_CHK_EN
            misalign  <= 1'b0;
`endif
        end else begin
            done    <= 1'b0;
            bus_err <= 1'b0;
`ifdef LDST_ALIGN_CHK_EN
            misalign <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (is_mem) begin
                        mem_wdata <= st_data;
                        mem_we    <= (opcode == OPCODE_ST);
                        wait_cnt  <= '0;
`ifdef LDST_ALIGN_CHK_EN
                        mem_addr  <= addr;
                        if (addr[1:0] != 2'b00) begin
                            // Misaligned: skip the bus entirely.
                            state    <= DONE;
                            done     <= 1'b1;
                            misalign <= 1'b1;
                        end else begin
                            state   <= REQ;
                            mem_req <= 1'b1;
                        end
`else
                        mem_addr  <= addr & 32'hffff_fffc;
                        state     <= REQ;
                        mem_req   <= 1'b1;
`endif
                    end
                end
                REQ: begin
                    // Ack is checked first so an ack on the timeout cycle wins.
                    if (mem_ack) begin
                        if (!mem_we) mem_out <= mem_rdata;
                        mem_req <= 1'b0;
                        done    <= 1'b1;
                        state   <= DONE;
                    end else if (wait_cnt == WAIT_LAST) begin
                        if (!mem_we) mem_out <= '0;
                        mem_req <= 1'b0;
                        done    <= 1'b1;
                        bus_err <= 1'b1;
                        state   <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state   <= IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ldst_unit.sv
// tb_ldst_unit: self-checking bench for ldst_unit.
// Table of directed transactions, hand-written reset/idle sequences, then random
// transactions checked against a transaction-level model of mem_out and timing.
module tb_ldst_unit;

    localparam int unsigned WAIT_MAX = 16;
    localparam logic [5:0] OP_LD   = 6'h23;
    localparam logic [5:0] OP_ST   = 6'h2b;
    localparam logic [5:0] OP_ADDU = 6'h00;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ex_valid = 1'b0;
    logic [5:0]  opcode = OP_ADDU;
    logic [31:0] addr = '0;
    logic [31:0] st_data = '0;
    logic        stall;
    logic        done;
    logic [31:0] mem_out;
    logic        bus_err;
`ifdef LDST_ALIGN_CHK_EN
    logic        misalign;
`endif
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;

    int          tests = 0;
    int          fails = 0;
    logic [31:0] model_out = '0;

    always #5 clk = ~clk;

    ldst_unit #(.WAIT_MAX(WAIT_MAX), .CNT_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ex_valid  (ex_valid),
        .opcode    (opcode),
        .addr      (addr),
        .st_data   (st_data),
        .stall     (stall),
        .done      (done),
        .mem_out   (mem_out),
        .bus_err   (bus_err),
`ifdef LDST_ALIGN_CHK_EN
        .misalign  (misalign),
`endif
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic is_misaligned(input logic [31:0] a);
`ifdef LDST_ALIGN_CHK_EN
        return a[1:0] != 2'b00;
`else
        return 1'b0;
`endif
    endfunction

    // delay = number of REQ cycles without ack before the ack cycle;
    // delay >= WAIT_MAX means the memory never answers.
    task automatic run_op(input logic is_st, input logic [31:0] a, input logic [31:0] d,
                          input int delay, input logic [31:0] rd, input int exp_n,
                          input logic exp_err, input logic [31:0] exp_out);
        int          n;
        logic        mis;
        logic [31:0] exp_addr;
        mis = is_misaligned(a);
`ifdef LDST_ALIGN_CHK_EN
        exp_addr = a;
`else
        exp_addr = {a[31:2], 2'b00};
`endif
        @(negedge clk);
        ex_valid = 1'b1;
        opcode   = is_st ? OP_ST : OP_LD;
        addr     = a;
        st_data  = d;
        #1;
        check("stall_accept", {31'd0, stall}, 32'd1);
        check("done_idle", {31'd0, done}, 32'd0);
        @(posedge clk);
        #1;
        // Scramble EX inputs so held bus fields are really latched copies.
        ex_valid = 1'b0;
        opcode   = OP_ADDU;
        addr     = $urandom;
        st_data  = $urandom;
        n = 0;
        for (int i = 0; i < int'(WAIT_MAX) + 4; i++) begin
            @(negedge clk);
            mem_ack   = 1'b0;
            mem_rdata = $urandom;
            if (!mem_req) break;
            n++;
            check("req_addr", mem_addr, exp_addr);
            check("req_we", {31'd0, mem_we}, {31'd0, is_st});
            check("req_wdata", mem_wdata, d);
            check("req_stall", {31'd0, stall}, 32'd1);
            if (n - 1 == delay) begin
                mem_ack   = 1'b1;
                mem_rdata = rd;
            end
        end
        check("req_cycles", n, exp_n);
        check("done", {31'd0, done}, 32'd1);
        check("bus_err", {31'd0, bus_err}, {31'd0, exp_err});
        check("done_stall", {31'd0, stall}, 32'd0);
        check("mem_out", mem_out, exp_out);
`ifdef LDST_ALIGN_CHK_EN
        check("misalign", {31'd0, misalign}, {31'd0, mis});
`else
        check("misalign_none", {31'd0, mis}, 32'd0);
`endif
    endtask

    typedef struct {
        logic        is_st;
        logic [31:0] a;
        logic [31:0] d;
        int          delay;
        logic [31:0] rd;
        int          exp_n;
        logic        exp_err;
        logic [31:0] exp_out;
    } vec_t;

    vec_t vecs[7];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b0, 32'h0000_0100, 32'h0, 0, 32'hCAFE_0001, 1, 1'b0, 32'hCAFE_0001};
        vecs[1] = '{1'b1, 32'h0000_0204, 32'h1234_5678, 3, 32'hDEAD_BEEF, 4, 1'b0, 32'hCAFE_0001};
        vecs[2] = '{1'b0, 32'h0000_0300, 32'h0, 99, 32'h0, 16, 1'b1, 32'h0};
        vecs[3] = '{1'b0, 32'h0000_0104, 32'h0, 15, 32'hAAAA_5555, 16, 1'b0, 32'hAAAA_5555};
        vecs[4] = '{1'b1, 32'h0000_0010, 32'h5A5A_A5A5, 40, 32'h0, 16, 1'b1, 32'hAAAA_5555};
`ifdef LDST_ALIGN_CHK_EN
        vecs[5] = '{1'b0, 32'h0000_0102, 32'h0, 1, 32'h0BAD_F00D, 0, 1'b0, 32'hAAAA_5555};
        vecs[6] = '{1'b0, 32'h0000_0008, 32'h0, 14, 32'h0000_0001, 15, 1'b0, 32'h0000_0001};
`else
        vecs[5] = '{1'b0, 32'h0000_0102, 32'h0, 1, 32'h0BAD_F00D, 2, 1'b0, 32'h0BAD_F00D};
        vecs[6] = '{1'b0, 32'h0000_0008, 32'h0, 14, 32'h0000_0001, 15, 1'b0, 32'h0000_0001};
`endif

        // Reset state.
        #3;
        check("rst_req", {31'd0, mem_req}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_out", mem_out, 32'd0);
        check("rst_addr", mem_addr, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed table, applied back-to-back.
        foreach (vecs[i]) begin
            run_op(vecs[i].is_st, vecs[i].a, vecs[i].d, vecs[i].delay, vecs[i].rd,
                   vecs[i].exp_n, vecs[i].exp_err, vecs[i].exp_out);
            model_out = vecs[i].exp_out;
        end

        // Non-memory opcode with a stray ack: nothing happens.
        @(negedge clk);
        ex_valid = 1'b1;
        opcode   = OP_ADDU;
        addr     = 32'h40;
        mem_ack  = 1'b1;
        #1;
        check("addu_stall", {31'd0, stall}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("addu_req", {31'd0, mem_req}, 32'd0);
            check("addu_done", {31'd0, done}, 32'd0);
            check("addu_out", mem_out, model_out);
        end
        mem_ack  = 1'b0;
        ex_valid = 1'b0;
        model_out = 32'h7777_0000;
        run_op(1'b0, 32'h0000_0500, 32'h0, 0, 32'h7777_0000, 1, 1'b0, model_out);

        // Reset asserted in the 2nd REQ cycle aborts without a clock edge.
        @(negedge clk);
        ex_valid = 1'b1;
        opcode   = OP_LD;
        addr     = 32'h0000_0040;
        @(posedge clk);
        #1;
        ex_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_mid_req_before", {31'd0, mem_req}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_req", {31'd0, mem_req}, 32'd0);
        check("rst_mid_stall", {31'd0, stall}, 32'd0);
        check("rst_mid_out", mem_out, 32'd0);
        model_out = '0;
        @(negedge clk);
        rst_n = 1'b1;
        model_out = 32'h1357_9BDF;
        run_op(1'b0, 32'h0000_0040, 32'h0, 2, 32'h1357_9BDF, 3, 1'b0, model_out);

        // Random transactions against the transaction-level model.
        for (int k = 0; k < 40; k++) begin
            logic        st;
            logic [31:0] a;
            logic [31:0] d;
            logic [31:0] rd;
            int          dl;
            int          en;
            logic        er;
            logic        mis;
            st  = 1'($urandom_range(0, 1));
            a   = $urandom;
            d   = $urandom;
            rd  = $urandom;
            dl  = int'($urandom_range(0, 20));
            mis = is_misaligned(a);
            er  = !mis && dl >= int'(WAIT_MAX);
            en  = mis ? 0 : ((dl >= int'(WAIT_MAX)) ? int'(WAIT_MAX) : dl + 1);
            if (!mis && !st) model_out = er ? 32'd0 : rd;
            run_op(st, a, d, dl, rd, en, er, model_out);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
